// File: rtl/md_unit_pkg.sv
// md_unit shared package
// Op encodings, default latencies, FSM states.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Multi-cycle ops that occupy the unit.
   function automatic logic is_md(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit E-stage port bundle
// Master is the pipeline, slave is md_unit.
interface md_unit_if;

   logic        start;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        HLSel;
   logic        D_md;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_out;

   modport master (
      output start, MDOp, A, B, HLSel, D_md,
      input  busy, stall, HI, LO, md_out
   );

   modport slave (
      input  start, MDOp, A, B, HLSel, D_md,
      output busy, stall, HI, LO, md_out
   );

endinterface

// File: rtl/md_alu.sv
// md_alu: combinational mult/div datapath
// Works on the latched op and operands.
module md_alu
   import md_unit_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        divz
);

   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               sgn;
   logic [31:0]        b_g;
   logic [31:0]        ma;
   logic [31:0]        mb;
   logic [31:0]        dvd;
   logic [31:0]        dvs;
   logic [31:0]        q;
   logic [31:0]        r;
   logic [31:0]        q_s;
   logic [31:0]        r_s;

   assign sa     = {{32{a[31]}}, a};
   assign sb     = {{32{b[31]}}, b};
   assign prod_s = sa * sb;
   assign prod_u = {32'b0, a} * {32'b0, b};

   assign divz = is_div(op) && (b == 32'b0);

   // One unsigned divider serves both div and divu;
   // signed div runs on magnitudes and fixes signs.
   assign sgn = (op == MD_DIV);
   assign b_g = (b == 32'b0) ? 32'd1 : b;
   assign ma  = a[31] ? (32'b0 - a) : a;
   assign mb  = b_g[31] ? (32'b0 - b_g) : b_g;
   assign dvd = sgn ? ma : a;
   assign dvs = sgn ? mb : b_g;
   assign q   = dvd / dvs;
   assign r   = dvd % dvs;
   assign q_s = (a[31] ^ b_g[31]) ? (32'b0 - q) : q;
   assign r_s = a[31] ? (32'b0 - r) : r;

   // Result select by latched op.
   always_comb begin
      hi = 32'b0;
      lo = 32'b0;
      unique case (1'b1)
         op == MD_MULT:  {hi, lo} = prod_s;
         op == MD_MULTU: {hi, lo} = prod_u;
         op == MD_DIV: begin
            hi = r_s;
            lo = q_s;
         end
         op == MD_DIVU: begin
            hi = r;
            lo = q;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO owner and mult/div sequencer
// Holds the op for a fixed latency, then commits.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   md_state_e   state;
   logic [CW-1:0] cnt;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_divz;

   md_alu u_alu (
      .op   (op_q),
      .a    (a_q),
      .b    (b_q),
      .hi   (res_hi),
      .lo   (res_lo),
      .divz (res_divz)
   );

   // FSM, counter and HI/LO; starts are ignored while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= 32'b0;
         lo_q   <= 32'b0;
         op_q   <= MD_NONE;
         a_q    <= 32'b0;
         b_q    <= 32'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (md.start) begin
                  unique case (1'b1)
                     is_md(md.MDOp): begin
                        op_q   <= md.MDOp;
                        a_q    <= md.A;
                        b_q    <= md.B;
                        cnt    <= is_div(md.MDOp) ?
                                  CW'(DIV_CYCLES) :
                                  CW'(MULT_CYCLES);
                        busy_q <= 1'b1;
                        state  <= S_BUSY;
                     end
                     md.MDOp == MD_MTHI: hi_q <= md.A;
                     md.MDOp == MD_MTLO: lo_q <= md.A;
                     default: ;
                  endcase
               end
            end
            S_BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (!res_divz) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign md.busy   = busy_q;
   assign md.HI     = hi_q;
   assign md.LO     = lo_q;
   assign md.md_out = md.HLSel ? hi_q : lo_q;
   assign md.stall  = md.D_md &
                      (busy_q | (md.start & is_md(md.MDOp)));

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench
// Hand-computed vectors for mult/div/mthi/mtlo/reset.
module tb_md_unit;
   import md_unit_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   md_unit_if mif ();

   md_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      mif.start = 1'b0;
      mif.MDOp  = MD_NONE;
      mif.A     = 32'b0;
      mif.B     = 32'b0;
   endtask

   // Issue op, count busy cycles, check stall each cycle.
   // inj: issue mthi 0x12345678 in the 2nd busy cycle.
   task automatic run_op(input string tag,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int n,
                         input logic dmd,
                         input logic inj);
      int cyc;
      mif.start = 1'b1;
      mif.MDOp  = op;
      mif.A     = a;
      mif.B     = b;
      mif.D_md  = dmd;
      #1;
      chk({tag, "_stall_t0"}, 32'(mif.stall), 32'(dmd));
      chk({tag, "_busy_t0"}, 32'(mif.busy), 32'd0);
      step();
      idle_in();
      cyc = 0;
      while (mif.busy && cyc < 40) begin
         chk({tag, "_stall_busy"}, 32'(mif.stall),
             32'(dmd));
         if (inj && cyc == 1) begin
            mif.start = 1'b1;
            mif.MDOp  = MD_MTHI;
            mif.A     = 32'h12345678;
         end else begin
            idle_in();
         end
         cyc++;
         step();
      end
      idle_in();
      #1;
      chk({tag, "_cycles"}, 32'(cyc), 32'(n));
      chk({tag, "_stall_idle"}, 32'(mif.stall), 32'd0);
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b1;
      mif.HLSel = 1'b0;
      mif.D_md  = 1'b1;
      idle_in();
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(mif.busy), 32'd0);
      chk("rst_stall", 32'(mif.stall), 32'd0);
      chk("rst_hi", mif.HI, 32'd0);
      chk("rst_lo", mif.LO, 32'd0);

      // mult -3*5 with mthi injected while busy
      run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd5,
             5, 1'b1, 1'b1);
      chk("mult_hi", mif.HI, 32'hFFFFFFFF);
      chk("mult_lo", mif.LO, 32'hFFFFFFF1);
      mif.HLSel = 1'b1;
      #1;
      chk("mdout_hi", mif.md_out, 32'hFFFFFFFF);
      mif.HLSel = 1'b0;
      #1;
      chk("mdout_lo", mif.md_out, 32'hFFFFFFF1);

      // back-to-back multu, same operands
      run_op("multu", MD_MULTU, 32'hFFFFFFFD, 32'd5,
             5, 1'b1, 1'b0);
      chk("multu_hi", mif.HI, 32'h00000004);
      chk("multu_lo", mif.LO, 32'hFFFFFFF1);

      run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2,
             10, 1'b1, 1'b0);
      chk("div_hi", mif.HI, 32'hFFFFFFFF);
      chk("div_lo", mif.LO, 32'hFFFFFFFD);

      run_op("divz", MD_DIVU, 32'd7, 32'd0,
             10, 1'b1, 1'b0);
      chk("divz_hi", mif.HI, 32'hFFFFFFFF);
      chk("divz_lo", mif.LO, 32'hFFFFFFFD);

      run_op("div2", MD_DIV, 32'd7, 32'hFFFFFFFE,
             10, 1'b0, 1'b0);
      chk("div2_hi", mif.HI, 32'h00000001);
      chk("div2_lo", mif.LO, 32'hFFFFFFFD);

      run_op("divov", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
             10, 1'b0, 1'b0);
      chk("divov_hi", mif.HI, 32'h00000000);
      chk("divov_lo", mif.LO, 32'h80000000);

      run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2,
             10, 1'b1, 1'b0);
      chk("divu_hi", mif.HI, 32'h00000001);
      chk("divu_lo", mif.LO, 32'h7FFFFFFC);

      // D_md low: stall must stay 0
      run_op("mult_nd", MD_MULT, 32'd7, 32'hFFFFFFFE,
             5, 1'b0, 1'b0);
      chk("mult_nd_hi", mif.HI, 32'hFFFFFFFF);
      chk("mult_nd_lo", mif.LO, 32'hFFFFFFF2);

      // mtlo / mthi while idle
      mif.D_md  = 1'b1;
      mif.start = 1'b1;
      mif.MDOp  = MD_MTLO;
      mif.A     = 32'hCAFEBABE;
      #1;
      chk("mtlo_stall", 32'(mif.stall), 32'd0);
      step();
      idle_in();
      chk("mtlo_lo", mif.LO, 32'hCAFEBABE);
      chk("mtlo_hi", mif.HI, 32'hFFFFFFFF);
      chk("mtlo_busy", 32'(mif.busy), 32'd0);
      mif.start = 1'b1;
      mif.MDOp  = MD_MTHI;
      mif.A     = 32'h0BADF00D;
      step();
      idle_in();
      chk("mthi_hi", mif.HI, 32'h0BADF00D);
      chk("mthi_lo", mif.LO, 32'hCAFEBABE);
      chk("mthi_busy", 32'(mif.busy), 32'd0);

      // start with MDOp none: no effect
      mif.start = 1'b1;
      mif.MDOp  = MD_NONE;
      mif.A     = 32'h55555555;
      step();
      idle_in();
      chk("none_busy", 32'(mif.busy), 32'd0);
      chk("none_hi", mif.HI, 32'h0BADF00D);

      // reset in 3rd busy cycle of div
      mif.start = 1'b1;
      mif.MDOp  = MD_DIV;
      mif.A     = 32'd100;
      mif.B     = 32'd7;
      step();
      idle_in();
      step();
      step();
      chk("rst3_busy_pre", 32'(mif.busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("rst3_busy", 32'(mif.busy), 32'd0);
      chk("rst3_hi", mif.HI, 32'd0);
      chk("rst3_lo", mif.LO, 32'd0);
      for (int i = 0; i < 12; i++) step();
      chk("rst3_busy_late", 32'(mif.busy), 32'd0);
      chk("rst3_lo_late", mif.LO, 32'd0);

      run_op("mult_rst", MD_MULT, 32'h00010000,
             32'h00010000, 5, 1'b1, 1'b0);
      chk("mult_rst_hi", mif.HI, 32'h00000001);
      chk("mult_rst_lo", mif.LO, 32'h00000000);

      // reset beats start in the same cycle
      reset     = 1'b1;
      mif.start = 1'b1;
      mif.MDOp  = MD_MULT;
      mif.A     = 32'd3;
      mif.B     = 32'd3;
      step();
      reset = 1'b0;
      idle_in();
      #1;
      chk("rstpri_busy", 32'(mif.busy), 32'd0);
      step();
      chk("rstpri_busy2", 32'(mif.busy), 32'd0);
      chk("rstpri_hi", mif.HI, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
